// File: rtl/sweep_pkg.sv
// Shared state encoding and width helper for the truth-table sweep engine.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/truth_table_sweep_hold_timer.sv
// Counts the cycles a combination is held and ticks on the last one.
module hold_timer
    import sweep_pkg::*;
#(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (clog2(HOLD) < 1) ? 1 : clog2(HOLD);
    localparam logic [W-1:0] LAST_COUNT = W'(HOLD - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST_COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Sweeps every input combination into a block under test, captures its
// responses into a truth table and compares that table against a golden one.
module truth_table_sweep
    import sweep_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic [(2**N_IN)*N_OUT-1:0]  expect_in,
    input  logic [N_OUT-1:0]            dut_in,
    output logic [N_IN-1:0]             stim_out,
    output logic [N_IN-1:0]             index_out,
    output logic [(2**N_IN)*N_OUT-1:0]  table_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        match_out
);

    localparam int TABLE_W = (2**N_IN) * N_OUT;
    localparam int IW      = N_IN + 1;
    localparam logic [IW-1:0] LAST_INDEX = IW'(2**N_IN - 1);

    sweep_state_t         state;
    sweep_state_t         state_next;
    logic [IW-1:0]        index;
    logic                 timer_enable;
    logic                 sample_tick;
    logic                 last_sample;
    logic [TABLE_W-1:0]   captured_table;

    assign timer_enable = (state == RUN) && !abort_in;
    assign last_sample  = sample_tick && (index == LAST_INDEX);
    assign stim_out     = index[N_IN-1:0];
    assign index_out    = index[N_IN-1:0];

    hold_timer #(
        .HOLD(HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (timer_enable),
        .clear   (!timer_enable),
        .tick    (sample_tick)
    );

    // Table as it will look once the current response is written in, so the
    // final compare sees the last slice on the same edge it is captured.
    always_comb begin
        captured_table = table_out;
        captured_table[int'(index[N_IN-1:0]) * N_OUT +: N_OUT] = dut_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = RUN;
            RUN: begin
                if (abort_in) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Abort takes priority over a sample on the same edge, so an aborted
    // sweep never pulses done_out or updates match_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index     <= '0;
            table_out <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            match_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        index     <= '0;
                        table_out <= '0;
                        busy_out  <= 1'b1;
                        match_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_in) begin
                        index    <= '0;
                        busy_out <= 1'b0;
                    end else if (sample_tick) begin
                        table_out <= captured_table;
                        if (last_sample) begin
                            index     <= '0;
                            busy_out  <= 1'b0;
                            done_out  <= 1'b1;
                            match_out <= (captured_table == expect_in);
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench: a 3-input/HOLD=2 sweeper and a 1-input/HOLD=1 corner sweeper.
module tb_truth_table_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;

    logic       start_a, abort_a;
    logic [7:0] expect_a;
    logic [0:0] dut_a;
    logic [2:0] stim_a, index_a;
    logic [7:0] table_a;
    logic       busy_a, done_a, match_a;

    logic       start_b, abort_b;
    logic [3:0] expect_b;
    logic [1:0] dut_b;
    logic [0:0] stim_b, index_b;
    logic [3:0] table_b;
    logic       busy_b, done_b, match_b;

    logic       use_rand;
    logic [7:0] rand_tt;

    int total = 0;
    int bad   = 0;

    // Blocks under test: majority-of-3 or a random truth table, and {stim,~stim}.
    assign dut_a = use_rand ? rand_tt[stim_a] : ($countones(stim_a) >= 2);
    assign dut_b = {stim_b[0], ~stim_b[0]};

    truth_table_sweep #(.N_IN(3), .N_OUT(1), .HOLD(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start_in(start_a), .abort_in(abort_a),
        .expect_in(expect_a), .dut_in(dut_a), .stim_out(stim_a), .index_out(index_a),
        .table_out(table_a), .busy_out(busy_a), .done_out(done_a), .match_out(match_a)
    );

    truth_table_sweep #(.N_IN(1), .N_OUT(2), .HOLD(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start_in(start_b), .abort_in(abort_b),
        .expect_in(expect_b), .dut_in(dut_b), .stim_out(stim_b), .index_out(index_b),
        .table_out(table_b), .busy_out(busy_b), .done_out(done_b), .match_out(match_b)
    );

    // Expected table after the first 'slices' combinations have been sampled.
    function automatic logic [7:0] model_table(input logic rnd, input logic [7:0] tt, input int slices);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < slices; i++) t[i] = rnd ? tt[i] : ($countones(i) >= 2);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total += 8;
        if (busy_a !== 1'b0)  begin bad++; $display("[TB] FAIL reset busy_a got=%b want=0", busy_a); end
        if (done_a !== 1'b0)  begin bad++; $display("[TB] FAIL reset done_a got=%b want=0", done_a); end
        if (match_a !== 1'b0) begin bad++; $display("[TB] FAIL reset match_a got=%b want=0", match_a); end
        if (stim_a !== 3'd0)  begin bad++; $display("[TB] FAIL reset stim_a got=%0d want=0", stim_a); end
        if (index_a !== 3'd0) begin bad++; $display("[TB] FAIL reset index_a got=%0d want=0", index_a); end
        if (table_a !== 8'h0) begin bad++; $display("[TB] FAIL reset table_a got=%h want=00", table_a); end
        if (busy_b !== 1'b0)  begin bad++; $display("[TB] FAIL reset busy_b got=%b want=0", busy_b); end
        if (table_b !== 4'h0) begin bad++; $display("[TB] FAIL reset table_b got=%h want=0", table_b); end
        reset_n = 1'b1;
        step();
    endtask

    // Full sweep on instance A; expect_in is disturbed after done to show match holds.
    task automatic test_full_sweep(input logic [7:0] exp_in, input string name);
        logic [7:0] exp_tab;
        logic       exp_match;
        int         ex_stim;
        logic       ex_busy, ex_done;
        exp_tab   = model_table(use_rand, rand_tt, 8);
        exp_match = (exp_tab == exp_in);
        expect_a  = exp_in;
        start_sweep_a();
        for (int c = 1; c <= 20; c++) begin
            step();
            ex_stim = (c < 16) ? c / 2 : 0;
            ex_busy = (c < 16);
            ex_done = (c == 16);
            total += 4;
            if (stim_a !== 3'(ex_stim))  begin bad++; $display("[TB] FAIL %s c=%0d stim got=%0d want=%0d", name, c, stim_a, ex_stim); end
            if (index_a !== 3'(ex_stim)) begin bad++; $display("[TB] FAIL %s c=%0d index got=%0d want=%0d", name, c, index_a, ex_stim); end
            if (busy_a !== ex_busy)      begin bad++; $display("[TB] FAIL %s c=%0d busy got=%b want=%b", name, c, busy_a, ex_busy); end
            if (done_a !== ex_done)      begin bad++; $display("[TB] FAIL %s c=%0d done got=%b want=%b", name, c, done_a, ex_done); end
            if (c == 16 || c == 20) begin
                total += 2;
                if (table_a !== exp_tab)   begin bad++; $display("[TB] FAIL %s c=%0d table got=%h want=%h", name, c, table_a, exp_tab); end
                if (match_a !== exp_match) begin bad++; $display("[TB] FAIL %s c=%0d match got=%b want=%b", name, c, match_a, exp_match); end
            end
            if (c == 18) expect_a = ~expect_a;
        end
    endtask

    task automatic test_abort(input int abort_cycle, input logic rnd, input string name);
        logic [7:0] exp_tab;
        int         dones;
        use_rand = rnd;
        rand_tt  = 8'($urandom);
        expect_a = model_table(rnd, rand_tt, 8);
        start_sweep_a();
        for (int c = 1; c <= abort_cycle; c++) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        exp_tab = model_table(rnd, rand_tt, abort_cycle / 2);
        total += 6;
        if (busy_a !== 1'b0)   begin bad++; $display("[TB] FAIL %s busy got=%b want=0", name, busy_a); end
        if (stim_a !== 3'd0)   begin bad++; $display("[TB] FAIL %s stim got=%0d want=0", name, stim_a); end
        if (index_a !== 3'd0)  begin bad++; $display("[TB] FAIL %s index got=%0d want=0", name, index_a); end
        if (done_a !== 1'b0)   begin bad++; $display("[TB] FAIL %s done got=%b want=0", name, done_a); end
        if (table_a !== exp_tab) begin bad++; $display("[TB] FAIL %s table got=%h want=%h", name, table_a, exp_tab); end
        if (match_a !== 1'b0)  begin bad++; $display("[TB] FAIL %s match got=%b want=0", name, match_a); end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done_a === 1'b1) dones++;
        end
        total += 2;
        if (dones !== 0)         begin bad++; $display("[TB] FAIL %s late_done got=%0d want=0", name, dones); end
        if (table_a !== exp_tab) begin bad++; $display("[TB] FAIL %s table_hold got=%h want=%h", name, table_a, exp_tab); end
    endtask

    task automatic test_idle_abort_and_start();
        logic [7:0] prev_table;
        int         done_cycle;
        use_rand   = 1'b0;
        expect_a   = 8'hE8;
        prev_table = table_a;
        abort_a    = 1'b1;
        step();
        total += 2;
        if (busy_a !== 1'b0)        begin bad++; $display("[TB] FAIL idle_abort busy got=%b want=0", busy_a); end
        if (table_a !== prev_table) begin bad++; $display("[TB] FAIL idle_abort table got=%h want=%h", table_a, prev_table); end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        total += 3;
        if (busy_a !== 1'b1)  begin bad++; $display("[TB] FAIL start_wins busy got=%b want=1", busy_a); end
        if (table_a !== 8'h0) begin bad++; $display("[TB] FAIL start_wins table got=%h want=00", table_a); end
        if (match_a !== 1'b0) begin bad++; $display("[TB] FAIL start_wins match got=%b want=0", match_a); end
        done_cycle = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done_a === 1'b1 && done_cycle < 0) done_cycle = c;
        end
        total += 2;
        if (done_cycle !== 16) begin bad++; $display("[TB] FAIL start_wins done_cycle got=%0d want=16", done_cycle); end
        if (match_a !== 1'b1)  begin bad++; $display("[TB] FAIL start_wins final_match got=%b want=1", match_a); end
    endtask

    task automatic test_back_to_back_start();
        int dones, done_cycle;
        use_rand = 1'b0;
        expect_a = 8'hE8;
        start_sweep_a();
        dones      = 0;
        done_cycle = -1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (done_a === 1'b1) begin dones++; done_cycle = c; end
            if (c > 16) begin
                total++;
                if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL busy_start c=%0d busy got=%b want=0", c, busy_a); end
            end
            start_a = (c == 6 || c == 7 || c == 15 || c == 16);
        end
        start_a = 1'b0;
        total += 4;
        if (dones !== 1)        begin bad++; $display("[TB] FAIL busy_start dones got=%0d want=1", dones); end
        if (done_cycle !== 16)  begin bad++; $display("[TB] FAIL busy_start done_cycle got=%0d want=16", done_cycle); end
        if (table_a !== 8'hE8)  begin bad++; $display("[TB] FAIL busy_start table got=%h want=e8", table_a); end
        if (match_a !== 1'b1)   begin bad++; $display("[TB] FAIL busy_start match got=%b want=1", match_a); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [7:0] partial;
        use_rand = 1'b0;
        expect_a = 8'hE8;
        start_sweep_a();
        for (int c = 1; c <= 9; c++) step();
        partial = model_table(1'b0, 8'h00, 4);
        total++;
        if (table_a !== partial) begin bad++; $display("[TB] FAIL mid_reset pre_table got=%h want=%h", table_a, partial); end
        #2;
        reset_n = 1'b0;
        #1;
        total += 5;
        if (busy_a !== 1'b0)  begin bad++; $display("[TB] FAIL mid_reset busy got=%b want=0", busy_a); end
        if (stim_a !== 3'd0)  begin bad++; $display("[TB] FAIL mid_reset stim got=%0d want=0", stim_a); end
        if (index_a !== 3'd0) begin bad++; $display("[TB] FAIL mid_reset index got=%0d want=0", index_a); end
        if (table_a !== 8'h0) begin bad++; $display("[TB] FAIL mid_reset table got=%h want=00", table_a); end
        if (done_a !== 1'b0)  begin bad++; $display("[TB] FAIL mid_reset done got=%b want=0", done_a); end
        step();
        reset_n = 1'b1;
        step();
        test_full_sweep(8'hE8, "after_reset");
    endtask

    task automatic test_corner();
        logic [3:0] exp_in;
        logic       exp_match;
        for (int run = 0; run < 2; run++) begin
            exp_in    = (run == 0) ? 4'b1001 : 4'b1001 ^ 4'(1 + $urandom_range(0, 14));
            exp_match = (exp_in == 4'b1001);
            expect_b  = exp_in;
            start_b   = 1'b1;
            step();
            start_b   = 1'b0;
            step();
            total += 3;
            if (busy_b !== 1'b1)  begin bad++; $display("[TB] FAIL corner c=1 busy got=%b want=1", busy_b); end
            if (stim_b !== 1'b1)  begin bad++; $display("[TB] FAIL corner c=1 stim got=%0d want=1", stim_b); end
            if (done_b !== 1'b0)  begin bad++; $display("[TB] FAIL corner c=1 done got=%b want=0", done_b); end
            step();
            total += 5;
            if (done_b !== 1'b1)      begin bad++; $display("[TB] FAIL corner c=2 done got=%b want=1", done_b); end
            if (busy_b !== 1'b0)      begin bad++; $display("[TB] FAIL corner c=2 busy got=%b want=0", busy_b); end
            if (stim_b !== 1'b0)      begin bad++; $display("[TB] FAIL corner c=2 stim got=%0d want=0", stim_b); end
            if (table_b !== 4'b1001)  begin bad++; $display("[TB] FAIL corner table got=%b want=1001", table_b); end
            if (match_b !== exp_match) begin bad++; $display("[TB] FAIL corner match got=%b want=%b", match_b, exp_match); end
            step();
            total++;
            if (done_b !== 1'b0) begin bad++; $display("[TB] FAIL corner c=3 done got=%b want=0", done_b); end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start_a  = 1'b0;
        abort_a  = 1'b0;
        expect_a = 8'h00;
        start_b  = 1'b0;
        abort_b  = 1'b0;
        expect_b = 4'h0;
        use_rand = 1'b0;
        rand_tt  = 8'h00;

        test_reset();
        test_full_sweep(8'hE8, "majority_match");
        test_full_sweep(8'hE9, "majority_mismatch");
        for (int r = 0; r < 4; r++) begin
            use_rand = 1'b1;
            rand_tt  = 8'($urandom);
            if (r % 2 == 0) test_full_sweep(model_table(1'b1, rand_tt, 8), "random_match");
            else            test_full_sweep(8'($urandom), "random_any");
        end
        test_abort(5, 1'b0, "abort_c5_majority");
        test_abort(5, 1'b1, "abort_c5_random");
        test_abort(15, 1'b1, "abort_final_edge");
        test_idle_abort_and_start();
        test_back_to_back_start();
        test_reset_mid_sweep();
        test_corner();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
Name: truth_table_sweep

Overview:
- Parametrised, sequential successor to the team's exhaustive-stimulus benches.
- Drives every combination of N_IN inputs into a combinational block under test and holds each one for HOLD cycles.
- Samples the block's N_OUT outputs for each combination, packs the results into a truth-table vector, and compares that vector against an expected table.
- Sits beside any small combinational block in lab designs, so an exhaustive check runs in hardware or simulation without hand-written stimulus.

Parameters:
- N_IN, 3, number of stimulus bits; sweep length is 2**N_IN combinations; legal range 1..8.
- N_OUT, 1, number of response bits sampled per combination; legal range ≥1.
- HOLD, 10, clock cycles each combination is held; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start_in  input  1  request a sweep; sampled only in IDLE.
- abort_in  input  1  cancel a running sweep.
- expect_in  input  (2**N_IN)*N_OUT  golden table; slice [i*N_OUT +: N_OUT] belongs to combination i.
- dut_in  input  N_OUT  response from the block under test.
- stim_out  output  N_IN  stimulus driven to the block under test.
- index_out  output  N_IN  current combination index.
- table_out  output  (2**N_IN)*N_OUT  captured truth table.
- busy_out  output  1  high while the sweep is in progress.
- done_out  output  1  one-cycle pulse when a sweep completes.
- match_out  output  1  table_out == expect_in; valid from done_out until the next start.

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - state=IDLE.
  - stim_out, index_out, table_out, busy_out, done_out, match_out, hold counter all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_in=1 at edge t0 → RUN.
  - Same edge: busy_out=1, stim_out=0, index_out=0, hold_cnt=0, table_out cleared to 0, match_out=0.
- RUN:
  - Each edge, hold_cnt increments.
  - At the edge where hold_cnt==HOLD-1 (the HOLD-th edge after the combination was applied):
    - dut_in is captured into table_out[index*N_OUT +: N_OUT].
    - hold_cnt→0.
  - If index < 2**N_IN-1 on that edge: index and stim_out increment by 1.
  - If index == 2**N_IN-1 on that edge: → DONE.
    - stim_out=0, index_out=0, busy_out=0, done_out=1.
    - match_out = (captured table incl. final slice == expect_in).
- DONE:
  - Lasts exactly one cycle.
  - done_out returns to 0 → IDLE.
  - table_out and match_out hold.
- Timing:
  - Sample edges are t0+k*HOLD for k=1..2**N_IN.
  - done_out is high in the cycle after edge t0+(2**N_IN)*HOLD.
  - stim_out changes only on sample edges, so the block under test gets HOLD-1 full cycles plus setup to settle.
- start_in while busy or in DONE: ignored (no restart, no queueing).
- abort_in=1 in RUN:
  - Next edge → IDLE; busy_out=0, stim_out=0, index_out=0.
  - done_out is not pulsed; match_out stays 0.
  - table_out keeps the partial contents.
- abort_in in IDLE/DONE: no effect.
- abort_in and a final sample on the same edge: abort wins; no done_out.
- abort_in and start_in together in IDLE: start wins.
- reset_n low mid-sweep: immediate return to reset values; partial table is lost.
- Counters:
  - hold_cnt width = clog2(HOLD), minimum 1.
  - index counts in N_IN+1 internal bits so the last-index test never wraps.
- expect_in is sampled only at the final sample edge; it may change at any other time.

Decomposition:
- Shared package (sweep_pkg):
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - function clog2 for counter widths.
- One natural sub-module, hold_timer: parametrised HOLD counter with enable/clear, emitting a one-cycle tick at HOLD-1.
- FSM, index/stimulus register, table capture and compare stay in truth_table_sweep.

Test Plan:
- Majority-of-3 model on dut_in (N_IN=3, N_OUT=1, HOLD=2), expect_in=8'hE8; pulse start → stim_out steps 0..7, every 2 cycles; done_out pulses once, 16 cycles after the start edge; table_out=8'hE8; match_out=1; busy_out=0.
- Same setup with expect_in=8'hE9 → table_out=8'hE8, match_out=0, done_out still pulses.
- Abort: start, then abort_in=1 at cycle 5 → next edge busy_out=0, stim_out=0, no done_out; table_out bits 0..1 captured (=2'b00), rest 0.
- Start while busy: second start_in pulse at cycle 7 → no restart; done_out still at cycle 16; exactly one done pulse.
- Reset mid-sweep: reset_n low at cycle 9 → all outputs 0 immediately, including table_out; after release, a fresh start gives the full correct 16-cycle sweep.
- Corner N_IN=1, HOLD=1, N_OUT=2, dut_in={stim,~stim}, expect_in=4'b1001 (slice 0 = 2'b01, slice 1 = 2'b10) → done_out 2 cycles after start; table_out=4'b1001; match_out=1.
